lsq_mem_sched: RTL and testbench

//  Sequences LSQ head entries onto the single data-memory port, strictly in program order, one access outstanding.

---
 rtl/lsq_pkg.sv | 25 ++
 rtl/lsq_mem_sched.sv | 154 +++++++++++++++
 tb/tb_lsq_mem_sched.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsq_pkg.sv
// Shared types for the LSQ memory scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lsq_pkg;

    localparam int TAG_WIDTH_DEF  = 4;
    localparam int ADDR_WIDTH_DEF = 32;
    localparam int DATA_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } lsq_sched_state_t;

    // One LSQ head entry as seen by the scheduler.
    typedef struct packed {
        logic                      is_load;
        logic [ADDR_WIDTH_DEF-1:0] addr;
        logic [DATA_WIDTH_DEF-1:0] data;
        logic [TAG_WIDTH_DEF-1:0]  tag;
    } lsq_req_t;

endpackage

// File: rtl/lsq_mem_sched.sv
// Purpose: issues LSQ head entries to the single data-memory port in program order, one access outstanding.
// Latency: load accept T -> req T+1 -> wb T+3 at best; store accept T -> st_done T+2.
// Backpressure: head is popped only from IDLE; mem_req with addr/we/wdata is held stable until mem_gnt.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   head_* / st_commit_ok / flush     LSQ head entry, ROB store permission, pipeline flush
//   head_pop                          combinational pop of the LSQ head
//   mem_req/we/addr/wdata, mem_gnt    request side of the memory handshake
//   mem_rvalid/rdata                  read return
//   ld_wb_valid/tag/data, st_done     one-cycle completion pulses
//   misalign_exc                      one-cycle misalignment pulse
// Build option: LSQ_MISALIGN_CHK_EN enables the misaligned-address check;
// without it misalign_exc is tied 0 and addresses go out unmodified.
module lsq_mem_sched
    import lsq_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int TAG_WIDTH  = TAG_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  head_valid,
    input  logic                  head_is_load,
    input  logic                  head_addr_rdy,
    input  logic [ADDR_WIDTH-1:0] head_addr,
    input  logic [DATA_WIDTH-1:0] head_data,
    input  logic [TAG_WIDTH-1:0]  head_tag,
    input  logic                  st_commit_ok,
    input  logic                  flush,
    output logic                  head_pop,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  ld_wb_valid,
    output logic [TAG_WIDTH-1:0]  ld_wb_tag,
    output logic [DATA_WIDTH-1:0] ld_wb_data,
    output logic                  st_done,
    output logic                  misalign_exc
);

    lsq_sched_state_t       state;
    logic                   hold_is_load;
    logic [TAG_WIDTH-1:0]   hold_tag;
    logic                   accept;
    logic                   misaligned;

    // Loads may go as soon as their address is known; stores also need the ROB's go-ahead.
    assign accept   = head_valid & head_addr_rdy & (head_is_load | st_commit_ok) & ~flush;
    assign head_pop = ~rst & (state == ST_IDLE) & accept;

`ifdef LSQ_MISALIGN_CHK_EN
    logic misalign_q;

    assign misaligned = |head_addr[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= head_pop & misaligned;
        end
    end

    assign misalign_exc = misalign_q;
`else
    assign misaligned   = 1'b0;
    assign misalign_exc = 1'b0;
`endif

    // mem_addr / mem_wdata double as the address/data hold registers: they are
    // loaded on accept and left untouched until the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            hold_is_load <= 1'b0;
            hold_tag     <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            ld_wb_valid  <= 1'b0;
            ld_wb_tag    <= '0;
            ld_wb_data   <= '0;
            st_done      <= 1'b0;
        end else begin
            ld_wb_valid <= 1'b0;
            st_done     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (misaligned) begin
                            // Complete immediately with an exception; memory is never touched.
                            ld_wb_valid <= head_is_load;
                            st_done     <= ~head_is_load;
                            ld_wb_tag   <= head_tag;
                            ld_wb_data  <= '0;
                        end else begin
                            state        <= ST_REQ;
                            mem_req      <= 1'b1;
                            mem_we       <= ~head_is_load;
                            mem_addr     <= head_addr;
                            mem_wdata    <= head_data;
                            hold_is_load <= head_is_load;
                            hold_tag     <= head_tag;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (!hold_is_load) begin
                            // A granted store is architecturally done even under flush.
                            st_done <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            state <= flush ? ST_DRAIN : ST_WAIT;
                        end
                    end else if (flush) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        state <= ST_IDLE;
                        if (!flush) begin
                            ld_wb_valid <= 1'b1;
                            ld_wb_tag   <= hold_tag;
                            ld_wb_data  <= mem_rdata;
                        end
                    end else if (flush) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // The squashed load's data still arrives; swallow it before reusing the port.
                    if (mem_rvalid) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsq_mem_sched.sv
// Testbench for lsq_mem_sched: directed scenarios followed by randomized traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_lsq_mem_sched;

    logic        clk;
    logic        rst;
    logic        head_valid;
    logic        head_is_load;
    logic        head_addr_rdy;
    logic [31:0] head_addr;
    logic [31:0] head_data;
    logic [3:0]  head_tag;
    logic        st_commit_ok;
    logic        flush;
    logic        head_pop;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        ld_wb_valid;
    logic [3:0]  ld_wb_tag;
    logic [31:0] ld_wb_data;
    logic        st_done;
    logic        misalign_exc;

    lsq_mem_sched dut (
        .clk          (clk),
        .rst          (rst),
        .head_valid   (head_valid),
        .head_is_load (head_is_load),
        .head_addr_rdy(head_addr_rdy),
        .head_addr    (head_addr),
        .head_data    (head_data),
        .head_tag     (head_tag),
        .st_commit_ok (st_commit_ok),
        .flush        (flush),
        .head_pop     (head_pop),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .ld_wb_valid  (ld_wb_valid),
        .ld_wb_tag    (ld_wb_tag),
        .ld_wb_data   (ld_wb_data),
        .st_done      (st_done),
        .misalign_exc (misalign_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the one access in flight, plus completions due next cycle.
    bit          m_busy, m_load, m_granted, m_squash;
    logic [31:0] m_addr, m_data;
    logic [3:0]  m_tag;
    bit          e_wb, e_st, e_mis;
    logic [3:0]  e_tag;
    logic [31:0] e_data;

    // Per-step observations used by the stimulus drivers.
    bit g_ld_gnt, g_pop;
    int pops;

    // Bench-side memory for the random phase.
    bit mem_pend;
    int mem_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_mis(input logic [31:0] a);
`ifdef LSQ_MISALIGN_CHK_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    // Called just after a negedge with this cycle's inputs already driven:
    // check outputs against the model, then advance the model across the posedge.
    task automatic step();
        bit exp_pop, exp_req;
        #1;
        exp_pop = !rst && !m_busy && head_valid && head_addr_rdy &&
                  (head_is_load || st_commit_ok) && !flush;
        exp_req = m_busy && !m_granted;
        chk("head_pop", head_pop, exp_pop);
        chk("mem_req", mem_req, exp_req);
        if (exp_req) begin
            chk("mem_we", mem_we, !m_load);
            chk("mem_addr", mem_addr, m_addr);
            if (!m_load) chk("mem_wdata", mem_wdata, m_data);
        end
        chk("ld_wb_valid", ld_wb_valid, e_wb);
        if (e_wb) begin
            chk("ld_wb_tag", ld_wb_tag, e_tag);
            chk("ld_wb_data", ld_wb_data, e_data);
        end
        chk("st_done", st_done, e_st);
        chk("misalign_exc", misalign_exc, e_mis);
        if (head_pop === 1'b1) pops++;

        g_ld_gnt = 0;
        g_pop    = exp_pop;
        e_wb = 0; e_st = 0; e_mis = 0;
        if (rst) begin
            m_busy = 0; m_granted = 0; m_squash = 0;
        end else if (!m_busy) begin
            if (exp_pop) begin
                if (is_mis(head_addr)) begin
                    e_mis = 1;
                    if (head_is_load) begin
                        e_wb = 1; e_tag = head_tag; e_data = 32'h0;
                    end else begin
                        e_st = 1;
                    end
                end else begin
                    m_busy = 1; m_granted = 0; m_squash = 0;
                    m_load = head_is_load; m_addr = head_addr;
                    m_data = head_data; m_tag = head_tag;
                end
            end
        end else if (!m_granted) begin
            if (mem_gnt) begin
                if (!m_load) begin
                    e_st = 1; m_busy = 0;
                end else begin
                    m_granted = 1; m_squash = flush; g_ld_gnt = 1;
                end
            end else if (flush) begin
                m_busy = 0;
            end
        end else begin
            if (mem_rvalid) begin
                m_busy = 0;
                if (!m_squash && !flush) begin
                    e_wb = 1; e_tag = m_tag; e_data = mem_rdata;
                end
            end else if (flush) begin
                m_squash = 1;
            end
        end
    endtask

    task automatic tick();
        step();
        @(negedge clk);
    endtask

    task automatic idle_in();
        rst = 0; head_valid = 0; head_is_load = 0; head_addr_rdy = 0;
        head_addr = 0; head_data = 0; head_tag = 0; st_commit_ok = 0;
        flush = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    endtask

    task automatic set_head(input bit ld, input logic [31:0] a, input logic [31:0] d, input logic [3:0] t);
        head_valid = 1; head_addr_rdy = 1; head_is_load = ld;
        head_addr = a; head_data = d; head_tag = t;
    endtask

    bit need_new;

    initial begin
        m_busy = 0; m_load = 0; m_granted = 0; m_squash = 0;
        m_addr = 0; m_data = 0; m_tag = 0;
        e_wb = 0; e_st = 0; e_mis = 0; e_tag = 0; e_data = 0;
        mem_pend = 0; mem_cnt = 0; pops = 0;
        idle_in();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_ld_wb_valid", ld_wb_valid, 0);
        chk("rst_st_done", st_done, 0);
        set_head(1, 32'h40, 0, 1);
        #1 chk("rst_head_pop", head_pop, 0);
        tick();

        // Best-case load: accept T, gnt T+1, rvalid T+2, writeback T+3
        idle_in(); tick();
        set_head(1, 32'h100, 32'h0, 4'd3);
        #1 chk("d1_pop", head_pop, 1);
        tick();
        idle_in(); mem_gnt = 1;
        #1 chk("d1_req", mem_req, 1);
        tick();
        idle_in(); mem_rvalid = 1; mem_rdata = 32'hDEADBEEF; tick();
        idle_in();
        chk("d1_wb_valid", ld_wb_valid, 1);
        chk("d1_wb_tag", ld_wb_tag, 3);
        chk("d1_wb_data", ld_wb_data, 32'hDEADBEEF);
        tick();

        // Store waits for commit permission
        idle_in(); set_head(0, 32'h200, 32'h55, 4'd5);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("d2_no_pop", head_pop, 0);
            chk("d2_no_req", mem_req, 0);
            tick();
        end
        st_commit_ok = 1;
        #1 chk("d2_pop", head_pop, 1);
        tick();
        idle_in(); mem_gnt = 1;
        chk("d2_we", mem_we, 1);
        chk("d2_wdata", mem_wdata, 32'h55);
        tick();
        idle_in();
        chk("d2_st_done", st_done, 1);
        tick();
        chk("d2_st_done_pulse", st_done, 0);

        // Grant withheld four cycles with a younger head waiting
        idle_in(); set_head(1, 32'h300, 0, 4'd7);
        pops = 0;
        tick();
        idle_in(); set_head(1, 32'h304, 0, 4'd8);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("d3_req", mem_req, 1);
            chk("d3_addr", mem_addr, 32'h300);
            chk("d3_we", mem_we, 0);
            tick();
        end
        mem_gnt = 1; tick();
        idle_in(); mem_rvalid = 1; mem_rdata = 32'h1234_5678; tick();
        idle_in();
        chk("d3_single_pop", pops, 1);
        chk("d3_wb_tag", ld_wb_tag, 7);
        tick();

        // Flush while waiting for load data
        idle_in(); set_head(1, 32'h400, 0, 4'd9); tick();
        idle_in(); mem_gnt = 1; tick();
        idle_in(); flush = 1; tick();
        idle_in(); set_head(1, 32'h500, 0, 4'd2);
        #1 chk("d4_drain_no_pop", head_pop, 0);
        tick();
        idle_in(); mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0; tick();
        idle_in();
        chk("d4_no_wb", ld_wb_valid, 0);
        set_head(1, 32'h500, 0, 4'd2);
        #1 chk("d4_next_pop", head_pop, 1);
        tick();
        idle_in(); mem_gnt = 1; tick();
        idle_in(); mem_rvalid = 1; mem_rdata = 32'hCAFEF00D; tick();
        idle_in(); tick();

        // Reset while waiting for load data
        idle_in(); set_head(1, 32'h600, 32'hAAAA, 4'd4); tick();
        idle_in(); mem_gnt = 1; tick();
        idle_in(); rst = 1; tick();
        idle_in();
        chk("d5_req", mem_req, 0);
        chk("d5_we", mem_we, 0);
        chk("d5_addr", mem_addr, 0);
        chk("d5_wdata", mem_wdata, 0);
        chk("d5_wb_valid", ld_wb_valid, 0);
        chk("d5_wb_tag", ld_wb_tag, 0);
        chk("d5_st_done", st_done, 0);
        mem_rvalid = 1; mem_rdata = 32'h77777777; tick();
        idle_in();
        chk("d5_late_rvalid", ld_wb_valid, 0);
        tick();

`ifdef LSQ_MISALIGN_CHK_EN
        // Misaligned load and store never reach memory
        idle_in(); set_head(1, 32'h102, 32'h0, 4'd6);
        #1 chk("d6_pop", head_pop, 1);
        tick();
        idle_in();
        chk("d6_mis", misalign_exc, 1);
        chk("d6_wb_valid", ld_wb_valid, 1);
        chk("d6_wb_data", ld_wb_data, 0);
        chk("d6_no_req", mem_req, 0);
        tick();
        chk("d6_mis_pulse", misalign_exc, 0);
        chk("d6_wb_pulse", ld_wb_valid, 0);
        set_head(0, 32'h203, 32'h99, 4'd1); st_commit_ok = 1; tick();
        idle_in();
        chk("d6_st_mis", misalign_exc, 1);
        chk("d6_st_done", st_done, 1);
        chk("d6_st_no_req", mem_req, 0);
        tick();
`else
        // Without the check, odd addresses go out unchanged
        idle_in(); set_head(1, 32'h102, 32'h0, 4'd6); tick();
        idle_in(); mem_gnt = 1;
        chk("d6_addr", mem_addr, 32'h102);
        chk("d6_no_mis", misalign_exc, 0);
        tick();
        idle_in(); mem_rvalid = 1; mem_rdata = 32'h0BAD_CAFE; tick();
        idle_in();
        chk("d6_no_mis_wb", misalign_exc, 0);
        tick();
`endif

        // Randomized traffic
        need_new = 1;
        mem_pend = 0;
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (need_new) begin
                head_is_load = $urandom_range(0, 1);
                head_addr    = $urandom & 32'hFFFF_FFFC;
                if ($urandom_range(0, 3) == 0) head_addr[1:0] = 2'($urandom_range(1, 3));
                head_data    = $urandom;
                head_tag     = 4'($urandom_range(0, 15));
                need_new     = 0;
            end
            head_valid    = ($urandom_range(0, 9) < 7);
            head_addr_rdy = ($urandom_range(0, 9) < 8);
            st_commit_ok  = $urandom_range(0, 1);
            flush         = ($urandom_range(0, 11) == 0);
            mem_gnt       = $urandom_range(0, 1);
            mem_rvalid    = 0;
            mem_rdata     = $urandom;
            if (mem_pend) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    mem_rvalid = 1;
                    mem_pend   = 0;
                end
            end else if (!(m_busy && m_granted) && $urandom_range(0, 7) == 0) begin
                mem_rvalid = 1;
            end
            tick();
            if (g_ld_gnt) begin
                mem_pend = 1;
                mem_cnt  = $urandom_range(1, 3);
            end
            if (rst) mem_pend = 0;
            if (g_pop || flush) need_new = 1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
